// File: rtl/counter_clk_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// counter_clk_if
//   Groups the control inputs and the seven-segment output of the counter
//   block so the board top and the bench connect through one bundle.
//   Signals:
//     up_down   1     0 = count up, 1 = count down
//     load      1     synchronous parallel load enable, active-high
//     data_in   4     value taken into the counter while load=1
//     disp_out  [0:6] segments a..g (index 0 = a), active-low (0 = lit)
//   Modports:
//     master  drives the controls, observes the display
//     slave   the counter itself: reads the controls, drives the display
// ----------------------------------------------------------------------------
interface counter_clk_if;
   logic       up_down;
   logic       load;
   logic [3:0] data_in;
   logic [0:6] disp_out;

   modport master (
      output up_down,
      output load,
      output data_in,
      input  disp_out
   );

   modport slave (
      input  up_down,
      input  load,
      input  data_in,
      output disp_out
   );
endinterface

// File: rtl/counter_clk.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// counter_clk
//   4-bit up/down counter with synchronous parallel load, stepped by an
//   internal clock-enable divider, decoded onto one active-low seven-segment
//   display. On the board DIV_COUNT slows counting to a visible rate; with
//   DIV_COUNT=1 the counter steps on every clock.
//   Parameters:
//     DIV_COUNT  clock cycles per count step (>= 1)
//   Ports:
//     clk    in  system clock, all state updates on the rising edge
//     reset  in  asynchronous, active-low; 0 clears counter and divider
//     bus    slave side of counter_clk_if (up_down, load, data_in, disp_out)
// ----------------------------------------------------------------------------
module counter_clk #(
   parameter int DIV_COUNT = 1
) (
   input  logic          clk,
   input  logic          reset,
   counter_clk_if.slave  bus
);

   localparam int             DIV_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

   logic [DIV_W-1:0] r_divCnt;
   logic [3:0]       r_count;
   logic             w_tick;
   logic [0:6]       w_seg;

   // The step enable fires on the last cycle of each divider period; with a
   // single-cycle period the divider sits at 0 and the enable is always high.
   assign w_tick = (r_divCnt == DIV_LAST);

   // Free-running divider. It is never held by load, so a load in the middle
   // of a period does not shift when the next count step happens.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_divCnt <= '0;
      end else if (w_tick) begin
         r_divCnt <= '0;
      end else begin
         r_divCnt <= r_divCnt + 1'b1;
      end
   end

   // Load has priority over counting and does not wait for the step enable.
   // The 4-bit add/subtract wraps naturally, giving F->0 up and 0->F down.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 4'h0;
      end else if (bus.load) begin
         r_count <= bus.data_in;
      end else if (w_tick) begin
         if (bus.up_down) begin
            r_count <= r_count - 4'h1;
         end else begin
            r_count <= r_count + 4'h1;
         end
      end
   end

   // Hex decode straight from the count register, so the display follows the
   // count in the same cycle. Codes are a..g left to right, 0 = segment lit.
   always_comb begin
      w_seg = 7'b1111111;
      case (r_count)
         4'h0: w_seg = 7'b0000001;
         4'h1: w_seg = 7'b1001111;
         4'h2: w_seg = 7'b0010010;
         4'h3: w_seg = 7'b0000110;
         4'h4: w_seg = 7'b1001100;
         4'h5: w_seg = 7'b0100100;
         4'h6: w_seg = 7'b0100000;
         4'h7: w_seg = 7'b0001111;
         4'h8: w_seg = 7'b0000000;
         4'h9: w_seg = 7'b0000100;
         4'hA: w_seg = 7'b0001000;
         4'hB: w_seg = 7'b1100000;
         4'hC: w_seg = 7'b0110001;
         4'hD: w_seg = 7'b1000010;
         4'hE: w_seg = 7'b0110000;
         4'hF: w_seg = 7'b0111000;
         default: w_seg = 7'b1111111;
      endcase
   end

   assign bus.disp_out = w_seg;

endmodule

// File: tb/tb_counter_clk.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_counter_clk
//   Drives two counter instances from one 2 ns clock: one stepping every
//   clock (DIV_COUNT=1) and one stepping every fourth clock (DIV_COUNT=4).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a period away from the rising edge that updates the counter.
// ----------------------------------------------------------------------------
module tb_counter_clk;

   logic clk;
   logic rst1;
   logic rst4;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic       upDown;
      logic       load;
      logic [3:0] dataIn;
      logic [3:0] expCount;
   } vec_t;

   vec_t vecs[$];

   counter_clk_if bus1 ();
   counter_clk_if bus4 ();

   counter_clk #(.DIV_COUNT(1)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1.slave)
   );

   counter_clk #(.DIV_COUNT(4)) dut4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4.slave)
   );

   // 2 ns clock period.
   initial clk = 1'b0;
   always #1 clk = ~clk;

   // Active-low segment codes for each hex digit, a..g left to right.
   function automatic logic [0:6] segOf(input logic [3:0] v);
      logic [0:6] s;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Put one table row onto the DIV_COUNT=1 instance.
   task automatic applyStimulus(input vec_t v);
      bus1.up_down = v.upDown;
      bus1.load    = v.load;
      bus1.data_in = v.dataIn;
   endtask

   // Compare one display sample and record the outcome.
   task automatic checkOutput(input string name, input logic [0:6] act, input logic [0:6] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: disp_out=%b, expected %b", name, act, exp);
      end
   endtask

   // Advance to the next falling edge after one rising edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] exp4a [8];
      logic [3:0] exp4b [5];

      testsRun    = 0;
      testsFailed = 0;

      rst1 = 1'b0;
      rst4 = 1'b0;
      bus1.up_down = 1'b0;
      bus1.load    = 1'b0;
      bus1.data_in = 4'h0;
      bus4.up_down = 1'b0;
      bus4.load    = 1'b0;
      bus4.data_in = 4'h0;

      // Reset display before any clock edge has occurred.
      #0.5;
      checkOutput("reset1_no_edge", bus1.disp_out, segOf(4'h0));
      checkOutput("reset4_no_edge", bus4.disp_out, segOf(4'h0));

      // Count up through the F->0 wrap and on to 3, then down through 0->F,
      // then loads, held loads and a load followed by an up wrap.
      for (int i = 0; i < 19; i++) begin
         vecs.push_back('{1'b0, 1'b0, 4'h0, 4'(i + 1)});
      end
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h2});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h1});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h0});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'hF});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'hE});
      vecs.push_back('{1'b1, 1'b1, 4'h5, 4'h5});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h4});
      vecs.push_back('{1'b1, 1'b1, 4'h5, 4'h5});
      vecs.push_back('{1'b1, 1'b1, 4'h5, 4'h5});
      vecs.push_back('{1'b1, 1'b1, 4'h5, 4'h5});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'h4});
      vecs.push_back('{1'b0, 1'b0, 4'h0, 4'h5});
      vecs.push_back('{1'b0, 1'b1, 4'hA, 4'hA});
      vecs.push_back('{1'b0, 1'b0, 4'h0, 4'hB});
      vecs.push_back('{1'b0, 1'b1, 4'hF, 4'hF});
      vecs.push_back('{1'b0, 1'b0, 4'h0, 4'h0});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 4'hF});

      @(negedge clk);
      rst1 = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("div1_vec%0d", i), bus1.disp_out, segOf(vecs[i].expCount));
      end

      // Asynchronous reset mid-cycle while showing F, then reset beats load.
      bus1.up_down = 1'b0;
      bus1.load    = 1'b1;
      bus1.data_in = 4'h7;
      #0.3;
      rst1 = 1'b0;
      #0.3;
      checkOutput("div1_async_reset", bus1.disp_out, segOf(4'h0));
      step();
      checkOutput("div1_reset_over_load", bus1.disp_out, segOf(4'h0));
      rst1 = 1'b1;
      bus1.load = 1'b0;
      step();
      checkOutput("div1_after_reset", bus1.disp_out, segOf(4'h1));

      // DIV_COUNT=4: one step per four clocks from release of reset.
      exp4a = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2};
      rst4 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checkOutput($sformatf("div4_count%0d", i), bus4.disp_out, segOf(exp4a[i]));
      end

      // Load lands on the very next edge even though the divider is mid-period,
      // and the divider phase is unaffected by it.
      bus4.load    = 1'b1;
      bus4.data_in = 4'h9;
      step();
      checkOutput("div4_load_next_edge", bus4.disp_out, segOf(4'h9));
      bus4.load    = 1'b0;
      bus4.data_in = 4'h0;
      exp4b = '{4'h9, 4'h9, 4'hA, 4'hA, 4'hA};
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput($sformatf("div4_after_load%0d", i), bus4.disp_out, segOf(exp4b[i]));
      end

      // Reset with the divider two cycles into a period; the divider must
      // restart from 0, so the first step comes four edges after release.
      #0.3;
      rst4 = 1'b0;
      #0.3;
      checkOutput("div4_async_reset", bus4.disp_out, segOf(4'h0));
      @(negedge clk);
      rst4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput($sformatf("div4_restart%0d", i), bus4.disp_out, segOf(exp4a[i]));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
